i2c_slave_mem: RTL and testbench

Synthesizable I2C target with a small byte-addressed register memory, placed on the far side of the SDA/SCL pins driven by the `i2c` master. It serves as an on-chip peripheral model and the loop-back target for master tests. It oversamples SCL/SDA on a single system clock and decodes START, STOP and repeated START. It supports pointer-based writes and auto-incrementing reads, and reports every written byte to local logic through a one-cycle strobe.

---
 rtl/i2c_slave_mem.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target with a byte-addressed register file; pointer writes, auto-incrementing reads, 3-cycle pin-event latency.
// No clock stretching; defining I2C_SLAVE_FILTER_EN adds a 3-sample majority glitch filter (5-cycle latency).
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MEM_BYTES = 16,
    localparam int        PW        = $clog2(MEM_BYTES)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          SCL,
    inout  wire           SDA,
    input  logic [PW-1:0] LOC_ADD,
    output logic [7:0]    LOC_DATA,
    output logic          WR_STROBE,
    output logic [PW-1:0] WR_ADD,
    output logic [7:0]    WR_DATA,
    output logic          BUSY
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          mack_q, mack_d;
    logic [7:0]    mem_q [MEM_BYTES];
    logic          we;
    logic [7:0]    rx_byte;
    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_s, sda_s, scl_prev_q, sda_prev_q;
    logic          scl_rise, scl_fall, start_evt, stop_evt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    // A value must be seen in two of three consecutive samples before it is believed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                          (scl_hist_q[0] & scl_hist_q[1]);
            sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                          (sda_hist_q[0] & sda_hist_q[1]);
        end
    end
    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // SDA moving in the same sample as SCL is a data edge, never START/STOP.
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = (ptr_q == PW'(MEM_BYTES - 1)) ? '0 : ptr_q + PW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        mack_d  = mack_q;
        we      = 1'b0;
        if (stop_evt) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            mack_d  = 1'b0;
        end else if (start_evt) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            mack_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            if ({1'b0, rx_byte} < 9'(MEM_BYTES)) begin
                                ptr_d   = rx_byte[PW-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                state_d = IGNORE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            we      = 1'b1;
                            ptr_d   = ptr_inc;
                            state_d = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (!sda_s) begin
                        ptr_d  = ptr_inc;
                        mack_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                        busy_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                // First fall starts the ACK clock, second fall ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d = 1'b0;
                        if (state_q == ADDR_ACK && shift_q[0]) begin
                            state_d = RDATA;
                            shift_d = mem_q[ptr_q];
                            oe_d    = ~mem_q[ptr_q][7];
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    oe_d    = ~shift_q[6];
                end
                RDATA_ACK: begin
                    if (mack_q) begin
                        state_d = RDATA;
                        shift_d = mem_q[ptr_q];
                        oe_d    = ~mem_q[ptr_q][7];
                        mack_d  = 1'b0;
                    end else begin
                        oe_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            mack_q    <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_ADD    <= '0;
            WR_DATA   <= '0;
            LOC_DATA  <= '0;
            for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            mack_q    <= mack_d;
            WR_STROBE <= we;
            LOC_DATA  <= mem_q[LOC_ADD];
            if (we) begin
                mem_q[ptr_q] <= rx_byte;
                WR_ADD       <= ptr_q;
                WR_DATA      <= rx_byte;
            end
        end
    end

    assign SDA  = oe_q ? 1'b0 : 1'bz;
    assign BUSY = busy_q;
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench: bit-banged I2C master against i2c_slave_mem with hand-computed expectations.
module tb_i2c_slave_mem;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [3:0] loc_add = '0;
    logic [7:0] loc_data;
    logic       wr_strobe;
    logic [3:0] wr_add;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda;

    int checks = 0;
    int failures = 0;
    int strb_n = 0;
    logic [3:0] strb_addr [16];
    logic [7:0] strb_data [16];
    int slave_low_cnt = 0;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_slave_mem #(.DEV_ADDR(7'h50), .MEM_BYTES(16)) dut (
        .CLK(clk), .RST_N(rst_n), .SCL(scl), .SDA(sda),
        .LOC_ADD(loc_add), .LOC_DATA(loc_data), .WR_STROBE(wr_strobe),
        .WR_ADD(wr_add), .WR_DATA(wr_data), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe && strb_n < 16) begin
            strb_addr[strb_n] = wr_add;
            strb_data[strb_n] = wr_data;
            strb_n++;
        end
        if (!sda_low && sda === 1'b0) slave_low_cnt++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; hold(Q);
        scl = 1'b1;     hold(2*Q);
        sda_low = 1'b1; hold(2*Q);
        scl = 1'b0;     hold(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; hold(Q);
        scl = 1'b1;     hold(2*Q);
        sda_low = 1'b0; hold(2*Q);
    endtask

    task automatic write_bit(input logic b);
        sda_low = ~b; hold(Q);
        scl = 1'b1;   hold(2*Q);
        scl = 1'b0;   hold(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_low = 1'b0; hold(Q);
        scl = 1'b1;     hold(Q);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        hold(Q);
        scl = 1'b0;     hold(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    task automatic test_reset();
        hold(3);
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (loc_data !== 8'h00) begin failures++; $display("FAIL reset_loc_data got=%h exp=00", loc_data); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
        checks++; if (wr_add !== 4'h0) begin failures++; $display("FAIL reset_wr_add got=%h exp=0", wr_add); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        hold(5);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        i2c_start();
        write_byte(8'hA0, a0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", busy); end
        write_byte(8'h03, a1);
        write_byte(8'h5A, a2);
        write_byte(8'hC3, a3);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL write_acks got=%b exp=0000", {a0, a1, a2, a3}); end
        checks++; if (strb_n !== 2) begin failures++; $display("FAIL write_strobe_count got=%0d exp=2", strb_n); end
        checks++; if (strb_addr[0] !== 4'd3 || strb_data[0] !== 8'h5A) begin failures++; $display("FAIL write_strobe0 got=%h/%h exp=3/5a", strb_addr[0], strb_data[0]); end
        checks++; if (strb_addr[1] !== 4'd4 || strb_data[1] !== 8'hC3) begin failures++; $display("FAIL write_strobe1 got=%h/%h exp=4/c3", strb_addr[1], strb_data[1]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
        loc_add = 4'd4; hold(2);
        checks++; if (loc_data !== 8'hC3) begin failures++; $display("FAIL write_loc4 got=%h exp=c3", loc_data); end
        loc_add = 4'd3; hold(2);
        checks++; if (loc_data !== 8'h5A) begin failures++; $display("FAIL write_loc3 got=%h exp=5a", loc_data); end
    endtask

    task automatic test_read_rs();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int n0;
        n0 = strb_n;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_nack got=%b exp=0", busy); end
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL read_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL read_byte0 got=%h exp=5a", d0); end
        checks++; if (d1 !== 8'hC3) begin failures++; $display("FAIL read_byte1 got=%h exp=c3", d1); end
        checks++; if (strb_n !== n0) begin failures++; $display("FAIL read_no_strobe got=%0d exp=%0d", strb_n, n0); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int n0, low0;
        n0 = strb_n;
        low0 = slave_low_cnt;
        i2c_start();
        write_byte(8'hA2, a0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrong_busy got=%b exp=0", busy); end
        write_byte(8'h00, a1);
        i2c_stop();
        checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL wrong_nacks got=%b exp=11", {a0, a1}); end
        checks++; if (slave_low_cnt !== low0) begin failures++; $display("FAIL wrong_sda_driven got=%0d exp=%0d", slave_low_cnt, low0); end
        checks++; if (strb_n !== n0) begin failures++; $display("FAIL wrong_no_strobe got=%0d exp=%0d", strb_n, n0); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] d;
        int n0;
        n0 = strb_n;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h0F, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL wrap_acks got=%b exp=0000", {a0, a1, a2, a3}); end
        checks++; if (strb_n !== n0 + 2) begin failures++; $display("FAIL wrap_strobe_count got=%0d exp=%0d", strb_n, n0 + 2); end
        checks++; if (strb_addr[n0] !== 4'd15 || strb_data[n0] !== 8'h11) begin failures++; $display("FAIL wrap_strobe0 got=%h/%h exp=f/11", strb_addr[n0], strb_data[n0]); end
        checks++; if (strb_addr[n0+1] !== 4'd0 || strb_data[n0+1] !== 8'h22) begin failures++; $display("FAIL wrap_strobe1 got=%h/%h exp=0/22", strb_addr[n0+1], strb_data[n0+1]); end
        i2c_start();
        write_byte(8'hA0, a4);
        write_byte(8'h04, a4);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, a5);
        write_byte(8'h10, a5);
        checks++; if (a5 !== 1'b1) begin failures++; $display("FAIL wrap_ptr_nack got=%b exp=1", a5); end
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, a6);
        read_byte(1'b1, d);
        i2c_stop();
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL wrap_ptr_kept got=%h exp=c3", d); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, a3, a4;
        int n0;
        n0 = strb_n;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h05, a1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        checks++; if (strb_n !== n0) begin failures++; $display("FAIL abort_no_strobe got=%0d exp=%0d", strb_n, n0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        i2c_start();
        write_byte(8'hA0, a2);
        write_byte(8'h06, a3);
        write_byte(8'h77, a4);
        i2c_stop();
        checks++; if ({a2, a3, a4} !== 3'b000) begin failures++; $display("FAIL abort_next_acks got=%b exp=000", {a2, a3, a4}); end
        checks++; if (strb_n !== n0 + 1 || strb_addr[n0] !== 4'd6 || strb_data[n0] !== 8'h77) begin
            failures++; $display("FAIL abort_next_strobe got=%0d:%h/%h exp=%0d:6/77", strb_n, strb_addr[n0], strb_data[n0], n0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(8'hA0 >> i);
        sda_low = 1'b0; hold(Q);
        scl = 1'b1;     hold(Q);
        checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rstmid_acking got=%b exp=0", sda); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rstmid_sda_release got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (wr_add !== 4'h0 || wr_data !== 8'h00 || wr_strobe !== 1'b0) begin
            failures++; $display("FAIL rstmid_wr got=%h/%h/%b exp=0/00/0", wr_add, wr_data, wr_strobe);
        end
        checks++; if (loc_data !== 8'h00) begin failures++; $display("FAIL rstmid_loc_data got=%h exp=00", loc_data); end
        hold(3);
        scl = 1'b0; hold(Q);
        rst_n = 1'b1;
        i2c_stop();
        loc_add = 4'd6; hold(2);
        checks++; if (loc_data !== 8'h00) begin failures++; $display("FAIL rstmid_mem_cleared got=%h exp=00", loc_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rs();
        test_wrong_addr();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
